// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg -- shared definitions for the access-control (ac_*) blocks.
//
// Contents:
//   ac_state_e      frame-sequencer state encoding (IDLE / RUN / DONE)
//   PIXEL_BITS      bits per pixel inside a UPSP write package
//   beats_per_row() output beats per destination row (BEATS_PER_ROW)
//   frame_beats()   output beats per destination frame (FRAME_BEATS)
//   cnt_width()     counter width for a modulo-n counter, never below 1
// ---------------------------------------------------------------------------
package ac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ac_state_e;

    localparam int PIXEL_BITS = 24;

    // Pixels per beat, clamped to 1 so a bad width parameter cannot cause a
    // divide-by-zero during elaboration (the top flags that case separately).
    function automatic int pixels_per_beat(input int wrt_width, input int n_par);
        int p;
        p = (wrt_width / PIXEL_BITS) * n_par;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int beats_per_row(input int wrt_width, input int n_par,
                                         input int dst_width);
        return dst_width / pixels_per_beat(wrt_width, n_par);
    endfunction

    function automatic int frame_beats(input int wrt_width, input int n_par,
                                       input int dst_width, input int dst_height);
        return beats_per_row(wrt_width, n_par, dst_width) * dst_height;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ac_skid_buf.sv
// ---------------------------------------------------------------------------
// ac_skid_buf -- 2-entry output FIFO built from a head register and a skid
// register. The head register drives the stream directly; the skid register
// absorbs one beat that arrives while the head is stalled.
//
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   push           write one beat (push_data) this cycle
//   push_data      beat to write
//   pop_ready      downstream ready; head is consumed when head_valid is high
//   head_valid     head entry holds a beat
//   head_data      head entry contents (cleared on reset)
//   count          number of valid entries (0..2)
//
// The producer must not push when the FIFO stays full across the cycle; the
// controller guarantees this through its credit check.
// ---------------------------------------------------------------------------
module ac_skid_buf #(
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic              head_valid_reg;
    logic [DATA_W-1:0] head_data_reg;
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              pop;

    assign pop = head_valid_reg && pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (!head_valid_reg || pop) begin
            // Head is free this cycle: refill from skid first to keep order,
            // otherwise take the incoming beat directly.
            if (skid_valid_reg) begin
                head_valid_reg <= 1'b1;
                head_data_reg  <= skid_data_reg;
                skid_valid_reg <= push;
                if (push) begin
                    skid_data_reg <= push_data;
                end
            end else begin
                head_valid_reg <= push;
                if (push) begin
                    head_data_reg <= push_data;
                end
            end
        end else if (push) begin
            // Head stalled: park the beat in the skid register.
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= push_data;
        end
    end

    assign head_valid = head_valid_reg;
    assign head_data  = head_data_reg;
    assign count      = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: rtl/ac_ostream_ctrl.sv
// ---------------------------------------------------------------------------
// ac_ostream_ctrl -- reads complete beats out of the wide output buffer and
// streams one destination frame over AXI-Stream per ctrl_start request.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   ctrl_start            single-cycle frame request (ignored unless idle)
//   ctrl_busy             high from accepted start until frame done
//   ctrl_done             one-cycle pulse after the last beat is accepted
//   buf_empty, buf_rd     wide buffer status / pop strobe
//   buf_rdata             buffer data, valid the cycle after buf_rd
//   m_axis_tvalid/tready  stream handshake
//   m_axis_tdata          beat data, unmodified
//   m_axis_tlast          last beat of a destination row
//   m_axis_tuser          first beat of a frame
// ---------------------------------------------------------------------------
module ac_ostream_ctrl
    import ac_pkg::*;
#(
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int N_PARALLEL         = 2,
    parameter int DST_IMG_WIDTH      = 4096,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     ctrl_start,
    output logic                                     ctrl_busy,
    output logic                                     ctrl_done,
    input  logic                                     buf_empty,
    output logic                                     buf_rd,
    input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0] buf_rdata,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0] m_axis_tdata,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tuser
);

    localparam int BEAT_W        = UPSP_WRTDATA_WIDTH * N_PARALLEL;
    localparam int N_UPSP_WRT    = UPSP_WRTDATA_WIDTH / PIXEL_BITS;
    localparam int BEATS_PER_ROW = beats_per_row(UPSP_WRTDATA_WIDTH, N_PARALLEL, DST_IMG_WIDTH);
    localparam int FRAME_BEATS   = frame_beats(UPSP_WRTDATA_WIDTH, N_PARALLEL,
                                               DST_IMG_WIDTH, DST_IMG_HEIGHT);
    localparam int COL_W         = cnt_width(BEATS_PER_ROW);
    localparam int ROW_W         = cnt_width(DST_IMG_HEIGHT);
    localparam int RD_W          = $clog2(FRAME_BEATS + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [RD_W-1:0]  RD_LIMIT = RD_W'(FRAME_BEATS);

    generate
        if (N_UPSP_WRT < 1 || (UPSP_WRTDATA_WIDTH % PIXEL_BITS) != 0) begin : g_bad_pkg_width
            $error("UPSP_WRTDATA_WIDTH must be a non-zero multiple of 24");
        end
        if (BEATS_PER_ROW * N_UPSP_WRT * N_PARALLEL != DST_IMG_WIDTH) begin : g_bad_row_width
            $error("DST_IMG_WIDTH is not a whole number of output beats");
        end
    endgenerate

    ac_state_e         state_reg, state_next;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [RD_W-1:0]   rd_cnt_reg;
    logic              rd_pend_reg;

    logic              head_valid;
    logic [BEAT_W-1:0] head_data;
    logic [1:0]        fifo_count;
    logic              out_fire;
    logic              last_col;
    logic              last_row;
    logic              frame_end;
    logic [2:0]        credit_used;

    assign out_fire  = head_valid && m_axis_tready;
    assign last_col  = (col_reg == COL_LAST);
    assign last_row  = (row_reg == ROW_LAST);
    assign frame_end = out_fire && last_col && last_row;

    // Entries that will be held once this cycle's pop and the pending read
    // land. Counting the pop as freed space lets a read issue in the same
    // cycle a beat leaves, which is what sustains one beat per cycle.
    assign credit_used = {1'b0, fifo_count} + {2'b00, rd_pend_reg} - {2'b00, out_fire};

    always_comb begin
        state_next = state_reg;
        buf_rd     = 1'b0;
        ctrl_busy  = 1'b0;
        ctrl_done  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ctrl_busy = 1'b1;
                buf_rd    = !buf_empty && (rd_cnt_reg < RD_LIMIT) && (credit_used < 3'd2);
                if (frame_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ctrl_busy  = 1'b1;
                ctrl_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            rd_cnt_reg  <= '0;
            rd_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= buf_rd;

            if (state_reg == ST_IDLE) begin
                rd_cnt_reg <= '0;
            end else if (buf_rd) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end

            // Position of the head beat in the frame; both counters wrap to
            // zero on the final beat, so the next frame starts at beat 0.
            if (out_fire) begin
                if (last_col) begin
                    col_reg <= '0;
                    row_reg <= last_row ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    ac_skid_buf #(
        .DATA_W (BEAT_W)
    ) u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_pend_reg),
        .push_data  (buf_rdata),
        .pop_ready  (m_axis_tready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign m_axis_tvalid = head_valid;
    assign m_axis_tdata  = head_data;
    assign m_axis_tlast  = head_valid && last_col;
    assign m_axis_tuser  = head_valid && (col_reg == '0) && (row_reg == '0);

endmodule
